// File: rtl/spm_bank_conflict_scheduler.sv
// spm_bank_conflict_scheduler
// Serializes one scratchpad vector request into bank-access beats so that
// no bank sees more than one lane per beat. Lanes that share a bank are
// served in ascending lane order, one per beat; the issuing core is
// backpressured through in_ready while the conflicts drain.
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready      request handshake
//   in_lane_mask           active lanes of the request
//   in_bank_indexes        bank per lane
//   in_bank_offsets        entry per lane
//   out_valid/out_ready    beat handshake toward the bank array
//   out_bank_en            banks accessed this beat
//   out_bank_lane          lane served by each bank (0 when disabled)
//   out_bank_offset        entry for each bank (0 when disabled)
//   out_lane_mask          lanes served this beat
//   out_last               final beat of the request
//   out_beat_cnt           0-based beat index within the request
module spm_bank_conflict_scheduler #(
  parameter int NUM_LANES  = 16,
  parameter int NUM_BANKS  = 16,
  parameter int ENTRY_W    = 8,
  parameter int LANE_IDX_W = $clog2(NUM_LANES),
  parameter int BANK_IDX_W = $clog2(NUM_BANKS)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [NUM_LANES-1:0]                   in_lane_mask,
  input  logic [NUM_LANES-1:0][BANK_IDX_W-1:0]   in_bank_indexes,
  input  logic [NUM_LANES-1:0][ENTRY_W-1:0]      in_bank_offsets,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [NUM_BANKS-1:0]                   out_bank_en,
  output logic [NUM_BANKS-1:0][LANE_IDX_W-1:0]   out_bank_lane,
  output logic [NUM_BANKS-1:0][ENTRY_W-1:0]      out_bank_offset,
  output logic [NUM_LANES-1:0]                   out_lane_mask,
  output logic                                   out_last,
  output logic [LANE_IDX_W:0]                    out_beat_cnt
);

  localparam int CNT_W = LANE_IDX_W + 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                               r_state;
  logic [NUM_LANES-1:0]                 r_pending;
  logic [NUM_LANES-1:0][BANK_IDX_W-1:0] r_bank;
  logic [NUM_LANES-1:0][ENTRY_W-1:0]    r_off;
  logic [CNT_W-1:0]                     r_beat_cnt;

  logic [NUM_BANKS-1:0]                 w_bank_en;
  logic [NUM_BANKS-1:0][LANE_IDX_W-1:0] w_bank_lane;
  logic [NUM_BANKS-1:0][ENTRY_W-1:0]    w_bank_off;
  logic [NUM_LANES-1:0]                 w_lane_mask;
  logic                                 w_last;
  logic                                 w_fire;
  logic                                 w_accept;

  // Each bank picks the lowest-index pending lane that targets it.
  always_comb begin
    logic v_found;
    w_bank_en   = '0;
    w_bank_lane = '0;
    w_bank_off  = '0;
    w_lane_mask = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      v_found = 1'b0;
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
        if (!v_found && r_pending[l] && (r_bank[l] == BANK_IDX_W'(b))) begin
          v_found        = 1'b1;
          w_bank_en[b]   = 1'b1;
          w_bank_lane[b] = LANE_IDX_W'(l);
          w_bank_off[b]  = r_off[l];
          w_lane_mask[l] = 1'b1;
        end
      end
    end
  end

  assign out_valid = (r_state == ISSUE);
  // Gated by out_valid so an idle scheduler never reports a last beat.
  assign w_last    = out_valid && ((r_pending & ~w_lane_mask) == '0);
  assign w_fire    = out_valid & out_ready;
  // Accepting on the final beat lets requests stream with no bubble.
  assign in_ready  = (r_state == IDLE) | (w_fire & w_last);
  assign w_accept  = in_valid & in_ready;

  assign out_bank_en     = w_bank_en;
  assign out_bank_lane   = w_bank_lane;
  assign out_bank_offset = w_bank_off;
  assign out_lane_mask   = w_lane_mask;
  assign out_last        = w_last;
  assign out_beat_cnt    = r_beat_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_pending  <= '0;
      r_bank     <= '0;
      r_off      <= '0;
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      // A zero mask is consumed here without ever entering ISSUE.
      r_bank     <= in_bank_indexes;
      r_off      <= in_bank_offsets;
      r_pending  <= in_lane_mask;
      r_beat_cnt <= '0;
      r_state    <= (|in_lane_mask) ? ISSUE : IDLE;
    end else if (w_fire) begin
      r_pending <= r_pending & ~w_lane_mask;
      if (w_last) begin
        r_state    <= IDLE;
        r_beat_cnt <= '0;
      end else if (r_beat_cnt != CNT_W'(NUM_LANES)) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

endmodule
